// File: rtl/ram8.sv
// ram8: 8-word x 16-bit register file built from 1-bit/16-bit gates and per-bit storage cells.
// Writes are steered by an 8-way demux on the load line; reads use an 8-way 16-bit mux tree.
module mux_gate (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = (a & ~sel) | (b & sel);
endmodule

module dmux_gate (
  input  logic x,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = x & ~sel;
  assign b = x & sel;
endmodule

module dmux4way (
  input  logic       x,
  input  logic [0:1] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);
  logic lo, hi;
  dmux_gate u_top (.x(x), .sel(sel[0]), .a(lo), .b(hi));
  dmux_gate u_lo (.x(lo), .sel(sel[1]), .a(a), .b(b));
  dmux_gate u_hi (.x(hi), .sel(sel[1]), .a(c), .b(d));
endmodule

module dmux8way (
  input  logic       x,
  input  logic [0:2] sel,
  output logic [0:7] y
);
  logic lo, hi;
  dmux_gate u_top (.x(x), .sel(sel[0]), .a(lo), .b(hi));
  dmux4way u_lo (.x(lo), .sel(sel[1:2]), .a(y[0]), .b(y[1]), .c(y[2]), .d(y[3]));
  dmux4way u_hi (.x(hi), .sel(sel[1:2]), .a(y[4]), .b(y[5]), .c(y[6]), .d(y[7]));
endmodule

module mux16 (
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic        sel,
  output logic [0:15] y
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    mux_gate u_mux (.a(a[i]), .b(b[i]), .sel(sel), .y(y[i]));
  end
endmodule

module mux4way16 (
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic [0:15] c,
  input  logic [0:15] d,
  input  logic [0:1]  sel,
  output logic [0:15] y
);
  logic [0:15] ab, cd;
  mux16 u_ab (.a(a), .b(b), .sel(sel[1]), .y(ab));
  mux16 u_cd (.a(c), .b(d), .sel(sel[1]), .y(cd));
  mux16 u_out (.a(ab), .b(cd), .sel(sel[0]), .y(y));
endmodule

module mux8way16 (
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic [0:15] c,
  input  logic [0:15] d,
  input  logic [0:15] e,
  input  logic [0:15] f,
  input  logic [0:15] g,
  input  logic [0:15] h,
  input  logic [0:2]  sel,
  output logic [0:15] y
);
  logic [0:15] lo, hi;
  mux4way16 u_lo (.a(a), .b(b), .c(c), .d(d), .sel(sel[1:2]), .y(lo));
  mux4way16 u_hi (.a(e), .b(f), .c(g), .d(h), .sel(sel[1:2]), .y(hi));
  mux16 u_out (.a(lo), .b(hi), .sel(sel[0]), .y(y));
endmodule

module bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic load,
  output logic q
);
  logic nxt;
  mux_gate u_hold (.a(q), .b(d), .sel(load), .y(nxt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= nxt;
endmodule

module register16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] d,
  input  logic        load,
  output logic [0:15] q
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    bit_cell u_bit (.clk(clk), .rst_n(rst_n), .d(d[i]), .load(load), .q(q[i]));
  end
endmodule

module ram8 #(
  parameter int N = 16
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic [0:N-1]  in_data,
  input  logic          in_load,
  input  logic [0:2]    in_address,
  output logic [0:N-1]  out_y
);
  logic [0:7]  load_line;
  logic [0:15] word [8];
  dmux8way u_steer (.x(in_load), .sel(in_address), .y(load_line));
  for (genvar i = 0; i < 8; i++) begin : g_word
    register16 u_reg (.clk(in_clk), .rst_n(in_rst_n), .d(in_data), .load(load_line[i]), .q(word[i]));
  end
  mux8way16 u_read (
    .a(word[0]), .b(word[1]), .c(word[2]), .d(word[3]),
    .e(word[4]), .f(word[5]), .g(word[6]), .h(word[7]),
    .sel(in_address), .y(out_y)
  );
endmodule
